posit_pio_responder: RTL and testbench
======================================

# posit_pio_responder

FPGA-fabric responder for the HPS operand/result PIO interface. The HPS writes two posit operands to the `num1`/`num2` PIOs and polls the `result` PIO. This block performs the following steps:

- Watches the two operand buses and waits until they are stable.
- Launches each new operand pair exactly once into the posit arithmetic core over a valid/ready request and a valid-only response.
- Drives the returned value back on `result_export`.
- Publishes posit NaR if the core does not respond within a bounded time.

## Interface
Parameters:
- `WIDTH`, 32, posit word width.
- `SETTLE_CYCLES`, 4, number of consecutive unchanged samples required before an operand pair is considered written.
- `TIMEOUT_CYCLES`, 256, maximum number of cycles spent in WAIT before NaR is published.

Ports:
- `clk_clk`  in  1  the single clock.
- `reset_reset_n`  in  1  reset, asynchronous, active-low.
- `num1_export`  in  WIDTH  operand A from HPS PIO.
- `num2_export`  in  WIDTH  operand B from HPS PIO.
- `result_export`  out  WIDTH  result to HPS PIO.
- `core_req_valid`  out  1  request valid.
- `core_req_ready`  in  1  core accepts request.
- `core_num1`  out  WIDTH  launched operand A.
- `core_num2`  out  WIDTH  launched operand B.
- `core_resp_valid`  in  1  single-cycle response strobe.
- `core_resp_data`  in  WIDTH  response value.
- `busy`  out  1  high when the FSM is in ISSUE or WAIT.
- `timeout_flag`  out  1  high when the last published result is a timeout NaR.

## Operation
- **Input stage:**
  - `num1_export`/`num2_export` are registered into `a_s`/`b_s`.
  - `stab_cnt` clears to 0 on any edge where the newly sampled pair differs from `{a_s,b_s}`.
  - Otherwise `stab_cnt` increments, saturating at `SETTLE_CYCLES`.
- **Pending condition:** `stab_cnt==SETTLE_CYCLES`, and either `launched==0` or `{a_s,b_s}` differs from the last launched pair `{la,lb}`.
- **FSM states:**
  - IDLE: when pending, load `la<=a_s`, `lb<=b_s`, set `launched<=1`, go to ISSUE.
  - ISSUE: `core_req_valid=1`; `core_num1/2` are driven from `la/lb` and held stable. When `core_req_ready` is high, go to WAIT and clear `timer`.
  - WAIT: `timer` increments each cycle.
    - On `core_resp_valid`: `result_export<=core_resp_data`, `timeout_flag<=0`, go to IDLE.
    - Else, when `timer==TIMEOUT_CYCLES-1`: `result_export<=1<<(WIDTH-1)` (NaR), `timeout_flag<=1`, go to IDLE.
- **Boundary rules:**
  - Operand changes during ISSUE/WAIT never alter `core_num1/2`. The new pair is launched from IDLE afterwards.
  - If `core_resp_valid` and the timeout fall in the same cycle, the response wins.
  - `core_resp_valid` in IDLE or ISSUE is ignored. This covers late responses after a timeout.
  - Rewriting an identical pair is not relaunched.
- **Reset values:** `result_export=0`, `core_req_valid=0`, `core_num1/2=0`, `busy=0`, `timeout_flag=0`, FSM=IDLE, `launched=0`, `stab_cnt=0`, `a_s/b_s=0`.
- **Reset mid-operation:** all state clears immediately. After release, the current inputs are relaunched once stable.

## Timing
- Inputs change before edge k: `a_s/b_s` update at edge k.
- `stab_cnt` reaches `SETTLE_CYCLES` at edge k+`SETTLE_CYCLES`.
- ISSUE is entered, and `core_req_valid` asserts, at edge k+`SETTLE_CYCLES`+1.
- Request handshake completes on the edge where `core_req_valid` and `core_req_ready` are both high.
- `result_export` updates on the edge that samples `core_resp_valid`.
- Timeout NaR appears `TIMEOUT_CYCLES` edges after WAIT entry.
- `busy` is registered and asserted exactly while the FSM is in ISSUE or WAIT.
- There is no combinational path from inputs to outputs.

## Configuration
- `POSIT_PIO_SYNC_EN` defined:
  - A 2-flop synchronizer stage is inserted ahead of `a_s/b_s`, for PIO outputs in a foreign clock domain.
  - Launch latency grows by 2 cycles.
  - Multi-bit skew is absorbed by the settle counter.
- Undefined: single input register, with latency as stated in Timing.

## Test plan
1. **Reset:** hold `reset_reset_n=0` with random inputs.
   - All outputs are 0.
   - No request issues while reset is held.
2. **Basic operation:** `num1=num2=0x40000000`; the core model is always ready and returns `0x48000000` 5 cycles after the handshake.
   - Exactly one request carrying `0x40000000/0x40000000`.
   - `result_export=0x48000000`.
   - No repeat request while the inputs stay constant.
3. **Settle filter:** toggle `num1` between `0x40000000` and `0x38000000` every 2 cycles for 20 cycles, then hold `0x38000000`.
   - No request during toggling.
   - One request with `num1=0x38000000` at hold+`SETTLE_CYCLES`+1.
4. **Timeout:** the core accepts the request but never responds.
   - `result_export=0x80000000` and `timeout_flag=1` 256 cycles after WAIT entry.
   - A late response is then ignored.
   - The next good response clears `timeout_flag`.
5. **Mid-operation change:** change `num2` to `0x50000000` during WAIT.
   - The first result is published with the old operands.
   - A second request carrying `0x50000000` follows.
   - Response and timeout in the same cycle publish the response.
6. **Reset during WAIT:** assert reset while in WAIT.
   - Outputs clear asynchronously.
   - The response arriving after release is ignored.
   - The held operands are relaunched once after settle.

Source files
------------

// File: rtl/posit_pio_responder.sv
// ---------------------------------------------------------------------------
// posit_pio_responder
//
// The HPS writes two posit operands to the num1/num2 PIOs and polls the
// result PIO. This block waits until the operand buses have been unchanged
// for SETTLE_CYCLES consecutive samples. It then launches each new operand
// pair exactly once into the posit core over a valid/ready request. The
// core's response is published on result_export. If the core stays silent
// for TIMEOUT_CYCLES cycles after accepting the request, posit NaR is
// published instead.
//
// Optional feature macro: POSIT_PIO_SYNC_EN
//   When defined, a 2-flop synchronizer sits ahead of the operand register
//   so the PIOs may live in a foreign clock domain (launch latency +2).
//
// Ports:
//   clk_clk          in   1      single clock
//   reset_reset_n    in   1      asynchronous active-low reset
//   num1_export      in   WIDTH  operand A from HPS PIO
//   num2_export      in   WIDTH  operand B from HPS PIO
//   result_export    out  WIDTH  published result (registered)
//   core_req_valid   out  1      request valid towards the posit core
//   core_req_ready   in   1      posit core accepts the request
//   core_num1        out  WIDTH  launched operand A (held for the request)
//   core_num2        out  WIDTH  launched operand B (held for the request)
//   core_resp_valid  in   1      single-cycle response strobe
//   core_resp_data   in   WIDTH  response value
//   busy             out  1      a request is being issued or awaited
//   timeout_flag     out  1      last published result is a timeout NaR
// ---------------------------------------------------------------------------
module posit_pio_responder #(
    parameter int WIDTH          = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] num1_export,
    input  logic [WIDTH-1:0] num2_export,
    output logic [WIDTH-1:0] result_export,
    output logic             core_req_valid,
    input  logic             core_req_ready,
    output logic [WIDTH-1:0] core_num1,
    output logic [WIDTH-1:0] core_num2,
    input  logic             core_resp_valid,
    input  logic [WIDTH-1:0] core_resp_data,
    output logic             busy,
    output logic             timeout_flag
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] NAR        = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [WIDTH-1:0] in_a_s, in_b_s;
    logic [WIDTH-1:0] a_r, b_r;
    logic [SW-1:0]    stab_r;
    logic             pair_changed_s;
    logic             pending_s;

    state_t           state_r, state_nx;
    logic [WIDTH-1:0] la_r, lb_r, la_nx, lb_nx;
    logic             launched_r, launched_nx;
    logic [TW-1:0]    timer_r, timer_nx;
    logic [WIDTH-1:0] result_r, result_nx;
    logic             tflag_r, tflag_nx;
    logic             req_valid_r, req_valid_nx;
    logic             busy_r, busy_nx;

`ifdef POSIT_PIO_SYNC_EN
    logic [WIDTH-1:0] sync1_a_r, sync1_b_r, sync2_a_r, sync2_b_r;

    // Two-flop synchronizer for operands coming from a foreign clock domain.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_a_r <= {WIDTH{1'b0}};
            sync1_b_r <= {WIDTH{1'b0}};
            sync2_a_r <= {WIDTH{1'b0}};
            sync2_b_r <= {WIDTH{1'b0}};
        end else begin
            sync1_a_r <= num1_export;
            sync1_b_r <= num2_export;
            sync2_a_r <= sync1_a_r;
            sync2_b_r <= sync1_b_r;
        end
    end

    assign in_a_s = sync2_a_r;
    assign in_b_s = sync2_b_r;
`else
    assign in_a_s = num1_export;
    assign in_b_s = num2_export;
`endif

    // A bus skewed across bits looks like several quick changes; the settle
    // counter restarts on each one, so only a quiet pair is ever launched.
    assign pair_changed_s = ({in_a_s, in_b_s} != {a_r, b_r});
    assign pending_s      = (stab_r == SETTLE_MAX) &&
                            (!launched_r || ({a_r, b_r} != {la_r, lb_r}));

    // Operand sample register and saturating stability counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            stab_r <= {SW{1'b0}};
        end else begin
            a_r <= in_a_s;
            b_r <= in_b_s;
            if (pair_changed_s) begin
                stab_r <= {SW{1'b0}};
            end else if (stab_r != SETTLE_MAX) begin
                stab_r <= stab_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                stab_r <= stab_r;
            end
        end
    end

    // Next-state and next-output logic of the launch FSM.
    always_comb begin
        state_nx    = state_r;
        la_nx       = la_r;
        lb_nx       = lb_r;
        launched_nx = launched_r;
        timer_nx    = timer_r;
        result_nx   = result_r;
        tflag_nx    = tflag_r;
        case (state_r)
            ST_IDLE: begin
                // Responses seen here (e.g. after a timeout) are dropped.
                if (pending_s) begin
                    la_nx       = a_r;
                    lb_nx       = b_r;
                    launched_nx = 1'b1;
                    state_nx    = ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (core_req_ready) begin
                    timer_nx = {TW{1'b0}};
                    state_nx = ST_WAIT;
                end else begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                timer_nx = timer_r + {{(TW-1){1'b0}}, 1'b1};
                // A response coinciding with the final timeout cycle wins.
                if (core_resp_valid) begin
                    result_nx = core_resp_data;
                    tflag_nx  = 1'b0;
                    state_nx  = ST_IDLE;
                end else if (timer_r == TIMER_LAST) begin
                    result_nx = NAR;
                    tflag_nx  = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // Decoded from the next state so the flops mirror the state exactly.
        req_valid_nx = (state_nx == ST_ISSUE);
        busy_nx      = (state_nx == ST_ISSUE) || (state_nx == ST_WAIT);
    end

    // FSM state, launched pair, timer and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r     <= ST_IDLE;
            la_r        <= {WIDTH{1'b0}};
            lb_r        <= {WIDTH{1'b0}};
            launched_r  <= 1'b0;
            timer_r     <= {TW{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            tflag_r     <= 1'b0;
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            la_r        <= la_nx;
            lb_r        <= lb_nx;
            launched_r  <= launched_nx;
            timer_r     <= timer_nx;
            result_r    <= result_nx;
            tflag_r     <= tflag_nx;
            req_valid_r <= req_valid_nx;
            busy_r      <= busy_nx;
        end
    end

    assign result_export  = result_r;
    assign timeout_flag   = tflag_r;
    assign core_req_valid = req_valid_r;
    assign busy           = busy_r;
    assign core_num1      = la_r;
    assign core_num2      = lb_r;

endmodule

// File: tb/tb_posit_pio_responder.sv
// ---------------------------------------------------------------------------
// tb_posit_pio_responder
//
// Self-checking bench for posit_pio_responder (default build). A transaction
// level reference model predicts every output after every clock edge. On top
// of that, a table of operand/response records and several hand-written
// sequences check the corner cases against hand-computed constants. These
// cover settle filtering, timeouts, late responses, mid-operation changes
// and reset during WAIT. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_posit_pio_responder;

    localparam int          W   = 32;
    localparam int          S   = 4;
    localparam int          T   = 256;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [31:0] num1_export, num2_export;
    logic [31:0] result_export;
    logic        core_req_valid, core_req_ready;
    logic [31:0] core_num1, core_num2;
    logic        core_resp_valid;
    logic [31:0] core_resp_data;
    logic        busy, timeout_flag;

    always #5 clk_clk = ~clk_clk;

    posit_pio_responder #(
        .WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .num1_export    (num1_export),
        .num2_export    (num2_export),
        .result_export  (result_export),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_num1      (core_num1),
        .core_num2      (core_num2),
        .core_resp_valid(core_resp_valid),
        .core_resp_data (core_resp_data),
        .busy           (busy),
        .timeout_flag   (timeout_flag)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sampled-pair history plus transaction status.
    logic [63:0] hist[$];
    bit          m_in_flight, m_accepted, m_launched, m_tflag;
    logic [31:0] m_la, m_lb, m_result;
    int          m_wait_edges;

    // Core stand-in and observation state.
    int          cd = 0;
    int          sched_delay = 0;
    bit          rand_core = 1'b0;
    bit          xor_mode = 1'b0;
    logic [31:0] core_data = 32'h0;
    bit          force_resp = 1'b0;
    logic [31:0] force_data = 32'h0;
    int          dut_launches = 0;
    bit          prev_req = 1'b0;
    logic [31:0] last_a = 32'h0, last_b = 32'h0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        int          delay;
        bit          late;
        logic [31:0] exp_result;
        bit          exp_tflag;
        int          exp_launches;
    } vec_t;

    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(64'd0);
        m_in_flight  = 1'b0;
        m_accepted   = 1'b0;
        m_launched   = 1'b0;
        m_tflag      = 1'b0;
        m_result     = 32'h0;
        m_la         = 32'h0;
        m_lb         = 32'h0;
        m_wait_edges = 0;
    endtask

    // True when the last S+1 sampled pairs are identical.
    function automatic bit model_stable();
        int n;
        n = hist.size();
        if (n < S + 1) return 1'b0;
        for (int i = n - S - 1; i < n; i++) begin
            if (hist[i] != hist[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the pre-edge inputs.
    task automatic model_edge();
        logic [63:0] sample;
        bit          handshake;
        sample    = {num1_export, num2_export};
        handshake = 1'b0;
        if (cd > 0) cd--;
        if (!reset_reset_n) begin
            model_reset();
        end else begin
            if (!m_in_flight) begin
                if (model_stable() && (!m_launched || hist[hist.size()-1] != {m_la, m_lb})) begin
                    m_in_flight  = 1'b1;
                    m_accepted   = 1'b0;
                    m_launched   = 1'b1;
                    {m_la, m_lb} = hist[hist.size()-1];
                end
            end else if (!m_accepted) begin
                if (core_req_ready) begin
                    m_accepted   = 1'b1;
                    m_wait_edges = 0;
                    handshake    = 1'b1;
                end
            end else begin
                m_wait_edges++;
                if (core_resp_valid) begin
                    m_result    = core_resp_data;
                    m_tflag     = 1'b0;
                    m_in_flight = 1'b0;
                end else if (m_wait_edges == T) begin
                    m_result    = NAR;
                    m_tflag     = 1'b1;
                    m_in_flight = 1'b0;
                end
            end
            hist.push_back(sample);
            if (hist.size() > S + 1) void'(hist.pop_front());
            if (handshake && sched_delay > 0) cd = sched_delay;
        end
    endtask

    task automatic check_outputs();
        check32("result", result_export, m_result);
        check1("timeout_flag", timeout_flag, m_tflag);
        check1("busy", busy, m_in_flight);
        check1("req_valid", core_req_valid, m_in_flight && !m_accepted);
        if (m_in_flight && !m_accepted) begin
            check32("core_num1", core_num1, m_la);
            check32("core_num2", core_num2, m_lb);
        end
    endtask

    // One clock: drive the core side, take the edge, update model, compare.
    task automatic cycle();
        if (rand_core) begin
            core_req_ready  = 1'($urandom_range(0, 1));
            core_resp_valid = ($urandom_range(0, 15) == 0);
            core_resp_data  = $urandom;
        end else begin
            core_req_ready  = 1'b1;
            core_resp_valid = (cd == 1) || force_resp;
            core_resp_data  = force_resp ? force_data : (xor_mode ? (m_la ^ m_lb) : core_data);
        end
        @(posedge clk_clk);
        model_edge();
        #1;
        check_outputs();
        if (core_req_valid && !prev_req) begin
            dut_launches++;
            last_a = core_num1;
            last_b = core_num2;
        end
        prev_req = core_req_valid;
    endtask

    // Run until the pair had time to launch and the model is idle again.
    task automatic run_settled(input string name, input int max_cycles, output int waitc);
        bit done;
        done  = 1'b0;
        waitc = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            cycle();
            if (busy && !core_req_valid) waitc++;
            if (i >= S + 3 && !m_in_flight) begin
                done = 1'b1;
                break;
            end
        end
        check1({name, "_done"}, done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string name);
        check32({name, "_result"}, result_export, 32'h0);
        check1({name, "_req_valid"}, core_req_valid, 1'b0);
        check32({name, "_core_num1"}, core_num1, 32'h0);
        check32({name, "_core_num2"}, core_num2, 32'h0);
        check1({name, "_busy"}, busy, 1'b0);
        check1({name, "_tflag"}, timeout_flag, 1'b0);
    endtask

    initial begin
        int          l0, waitc, first;
        bit          ok;
        logic [31:0] cap1;
        logic [31:0] pool [4];

        vecs[0] = '{32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 5,   1'b0, 32'h4800_0000, 1'b0, 1};
        vecs[1] = '{32'h4000_0000, 32'h4000_0000, 32'h1111_1111, 5,   1'b0, 32'h4800_0000, 1'b0, 0};
        vecs[2] = '{32'h3800_0000, 32'h4000_0000, 32'h4400_0000, 3,   1'b0, 32'h4400_0000, 1'b0, 1};
        vecs[3] = '{32'h1234_5678, 32'h9abc_def0, 32'h0000_0000, 0,   1'b1, 32'h8000_0000, 1'b1, 1};
        vecs[4] = '{32'h1234_5678, 32'h0000_0001, 32'h5a5a_5a5a, 1,   1'b0, 32'h5a5a_5a5a, 1'b0, 1};
        vecs[5] = '{32'h7fff_ffff, 32'h8000_0000, 32'h0f0f_0f0f, 255, 1'b0, 32'h0f0f_0f0f, 1'b0, 1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h00c0_ffee, 256, 1'b0, 32'h00c0_ffee, 1'b0, 1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h2222_2222, 1,   1'b0, 32'h00c0_ffee, 1'b0, 0};
        pool = '{32'h0000_0000, 32'h4000_0000, 32'h3800_0000, 32'hc000_0000};

        reset_reset_n   = 1'b0;
        num1_export     = 32'h0;
        num2_export     = 32'h0;
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_resp_data  = 32'h0;
        model_reset();

        // Reset held with random operands: everything stays at zero.
        for (int i = 0; i < 8; i++) begin
            num1_export = $urandom;
            num2_export = $urandom;
            cycle();
            check_reset_outputs("reset");
        end
        reset_reset_n = 1'b1;

        // Table-driven transactions with a scheduled-response core.
        for (int r = 0; r < 8; r++) begin
            num1_export = vecs[r].a;
            num2_export = vecs[r].b;
            core_data   = vecs[r].data;
            sched_delay = vecs[r].delay;
            l0          = dut_launches;
            run_settled($sformatf("vec%0d", r), 700, waitc);
            if (vecs[r].late) begin
                force_resp = 1'b1;
                force_data = 32'hdead_beef;
                cycle();
                force_resp = 1'b0;
            end
            check32($sformatf("vec%0d_result", r), result_export, vecs[r].exp_result);
            check1($sformatf("vec%0d_tflag", r), timeout_flag, vecs[r].exp_tflag);
            check_int($sformatf("vec%0d_launches", r), dut_launches - l0, vecs[r].exp_launches);
            if (vecs[r].exp_launches == 1) begin
                check_int($sformatf("vec%0d_wait_cycles", r), waitc,
                          (vecs[r].delay == 0) ? T : vecs[r].delay);
                check32($sformatf("vec%0d_req_num1", r), last_a, vecs[r].a);
                check32($sformatf("vec%0d_req_num2", r), last_b, vecs[r].b);
            end
        end

        // Settle filter: toggling num1 every 2 cycles never launches.
        xor_mode    = 1'b1;
        sched_delay = 2;
        num2_export = 32'h4000_0000;
        l0          = dut_launches;
        for (int i = 0; i < 20; i++) begin
            num1_export = (((i / 2) % 2) == 0) ? 32'h3800_0000 : 32'h4000_0000;
            cycle();
        end
        check_int("settle_no_req", dut_launches - l0, 0);
        num1_export = 32'h3800_0000;
        first       = 0;
        cap1        = 32'h0;
        for (int j = 1; j <= S + 6; j++) begin
            cycle();
            if (core_req_valid && first == 0) begin
                first = j;
                cap1  = core_num1;
            end
        end
        check_int("settle_req_cycle", first, S + 2);
        check32("settle_req_num1", cap1, 32'h3800_0000);
        run_settled("settle_finish", 100, waitc);
        check32("settle_result", result_export, 32'h7800_0000);
        check_int("settle_launches", dut_launches - l0, 1);

        // Operand change during WAIT: old pair published, new pair follows.
        num1_export = 32'h1100_0000;
        num2_export = 32'h2200_0000;
        sched_delay = 20;
        l0          = dut_launches;
        ok          = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            ok = m_in_flight && m_accepted;
        end
        check1("midop_accepted", ok, 1'b1);
        num2_export = 32'h5000_0000;
        ok          = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            cycle();
            ok = !m_in_flight;
        end
        check1("midop_first_done", ok, 1'b1);
        check32("midop_first_result", result_export, 32'h3300_0000);
        run_settled("midop_second", 200, waitc);
        check_int("midop_launches", dut_launches - l0, 2);
        check32("midop_req2_num2", last_b, 32'h5000_0000);
        check32("midop_second_result", result_export, 32'h4100_0000);

        // Reset during WAIT, with the core response arriving after release.
        num1_export = 32'h0a00_0000;
        num2_export = 32'h0b00_0000;
        sched_delay = 10;
        ok          = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            ok = m_in_flight && m_accepted;
        end
        check1("rstwait_accepted", ok, 1'b1);
        for (int i = 0; i < 7; i++) cycle();
        check1("rstwait_busy_before", busy, 1'b1);
        #2;
        reset_reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rstwait_async");
        cycle();
        reset_reset_n = 1'b1;
        l0 = dut_launches;
        cycle();
        cycle();
        check32("rstwait_late_ignored", result_export, 32'h0);
        run_settled("rstwait_relaunch", 200, waitc);
        check_int("rstwait_launches", dut_launches - l0, 1);
        check32("rstwait_req_num1", last_a, 32'h0a00_0000);
        check32("rstwait_result", result_export, 32'h0100_0000);
        for (int i = 0; i < 12; i++) cycle();
        check_int("rstwait_no_repeat", dut_launches - l0, 1);

        // Randomized phase: random core behaviour, operands and resets.
        rand_core = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) num1_export = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) num2_export = pool[$urandom_range(0, 3)];
            reset_reset_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rand_core     = 1'b0;
        reset_reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
